// File: rtl/mmv_input_packer_pkg.sv
// rtl/mmv_input_packer_pkg.sv - width helpers and lane packing shared by MMV blocks
package mmv_pkg;

  // Widest packed beat any MMV block may build through lane_insert.
  localparam int MAX_W = 512;

  function automatic int calc_widthb(input int simd, input int prec);
    return simd * prec;
  endfunction

  function automatic int calc_widtha(input int mmv, input int simd, input int prec);
    return mmv * simd * prec;
  endfunction

  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Keep lanes below `lane`, drop `word` into `lane`, zero everything above it.
  function automatic logic [MAX_W-1:0] lane_insert(input logic [MAX_W-1:0] acc,
                                                   input logic [MAX_W-1:0] word,
                                                   input int lane, input int wb);
    logic [MAX_W-1:0] keep;
    logic [MAX_W-1:0] wmask;
    keep  = ~({MAX_W{1'b1}} << (lane * wb));
    wmask = ~({MAX_W{1'b1}} << wb);
    return (acc & keep) | ((word & wmask) << (lane * wb));
  endfunction

endpackage

// File: rtl/mmv_input_packer_if.sv
// rtl/mmv_input_packer_if.sv - single-word input stream and packed output stream interfaces
interface mmv_axis_in_if #(parameter int W = 8);
  logic [W-1:0] tdata;
  logic         tvalid;
  logic         tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

interface mmv_axis_out_if #(parameter int W = 16);
  logic [W-1:0] tdata;
  logic         tvalid;
  logic         tready;
  logic         tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/mmv_input_packer_out_reg.sv
// rtl/mmv_input_packer_out_reg.sv - one-deep valid/ready register holding data plus last
module mmv_out_reg #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         load_last,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] data,
  output logic         last
);

  logic         valid_q, valid_d;
  logic         last_q, last_d;
  logic [W-1:0] data_q, data_d;

  // A load in the same cycle as a pop keeps valid high with the new contents.
  always_comb begin
    valid_d = valid_q;
    last_d  = last_q;
    data_d  = data_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = load_data;
      last_d  = load_last;
    end else if (ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      last_q  <= last_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;
  assign last  = last_q;

endmodule

// File: rtl/mmv_input_packer.sv
// rtl/mmv_input_packer.sv - packs MMV input words per beat, pads and flags the frame end
// Optional MMV_ROW_ALIGN_EN: every row also closes a beat, so rows start at lane 0.
module mmv_input_packer
  import mmv_pkg::*;
#(
  parameter int SIMD         = 1,
  parameter int IP_PRECISION = 8,
  parameter int MMV          = 2,
  parameter int IFMChannels  = 2,
  parameter int IFMWidth     = 8,
  parameter int IFMHeight    = 8
) (
  input  logic          clk,
  input  logic          reset,
  mmv_axis_in_if.slave  ip_axis,
  mmv_axis_out_if.master op_axis,
  output logic          frame_done
);

  localparam int EFF_CHANNELS = IFMChannels / SIMD;
  localparam int ROW_WORDS    = IFMWidth * EFF_CHANNELS;
  localparam int FRAME_WORDS  = ROW_WORDS * IFMHeight;
  localparam int WIDTHB       = calc_widthb(SIMD, IP_PRECISION);
  localparam int WIDTHA       = calc_widtha(MMV, SIMD, IP_PRECISION);
  localparam int LW           = cnt_width(MMV);
  localparam int WW           = cnt_width(FRAME_WORDS + 1);
  localparam logic [LW-1:0] LAST_LANE = LW'(MMV - 1);
  localparam logic [WW-1:0] LAST_WORD = WW'(FRAME_WORDS - 1);

  logic [LW-1:0]     lane_cnt_q, lane_cnt_d;
  logic [WW-1:0]     word_cnt_q, word_cnt_d;
  logic [WIDTHA-1:0] acc_q, acc_d;
  logic              rdy_en_q, rdy_en_d;
  logic              frame_done_q, frame_done_d;

  logic              frame_end, row_end, completing, in_fire, op_fire;
  logic              out_valid, out_last;
  logic [WIDTHA-1:0] packed_word, out_data;

`ifdef MMV_ROW_ALIGN_EN
  localparam int CW = cnt_width(ROW_WORDS + 1);
  localparam logic [CW-1:0] LAST_COL = CW'(ROW_WORDS - 1);
  logic [CW-1:0] col_cnt_q, col_cnt_d;

  assign row_end = (col_cnt_q == LAST_COL);

  always_comb begin
    col_cnt_d = col_cnt_q;
    if (in_fire) col_cnt_d = row_end ? '0 : col_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) col_cnt_q <= '0;
    else       col_cnt_q <= col_cnt_d;
  end
`else
  assign row_end = 1'b0;
`endif

  assign frame_end  = (word_cnt_q == LAST_WORD);
  assign completing = (lane_cnt_q == LAST_LANE) || frame_end || row_end;
  // Only a beat-completing word can stall, and only behind a held output beat.
  assign ip_axis.tready = rdy_en_q && (!completing || !out_valid || op_axis.tready);
  assign in_fire    = ip_axis.tvalid && ip_axis.tready;
  assign op_fire    = out_valid && op_axis.tready;
  assign packed_word = WIDTHA'(lane_insert(MAX_W'(acc_q), MAX_W'(ip_axis.tdata),
                                           int'(lane_cnt_q), WIDTHB));

  always_comb begin
    lane_cnt_d   = lane_cnt_q;
    word_cnt_d   = word_cnt_q;
    acc_d        = acc_q;
    rdy_en_d     = 1'b1;
    frame_done_d = op_fire && out_last;
    if (in_fire) begin
      word_cnt_d = frame_end ? '0 : word_cnt_q + 1'b1;
      if (completing) begin
        lane_cnt_d = '0;
        acc_d      = '0;
      end else begin
        lane_cnt_d = lane_cnt_q + 1'b1;
        acc_d      = packed_word;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lane_cnt_q   <= '0;
      word_cnt_q   <= '0;
      acc_q        <= '0;
      rdy_en_q     <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      lane_cnt_q   <= lane_cnt_d;
      word_cnt_q   <= word_cnt_d;
      acc_q        <= acc_d;
      rdy_en_q     <= rdy_en_d;
      frame_done_q <= frame_done_d;
    end
  end

  mmv_out_reg #(.W(WIDTHA)) u_out_reg (
    .clk       (clk),
    .reset     (reset),
    .load      (in_fire && completing),
    .load_data (packed_word),
    .load_last (frame_end),
    .ready     (op_axis.tready),
    .valid     (out_valid),
    .data      (out_data),
    .last      (out_last)
  );

  assign op_axis.tvalid = out_valid;
  assign op_axis.tdata  = out_data;
  assign op_axis.tlast  = out_last;
  assign frame_done     = frame_done_q;

endmodule
